serial_divider: RTL



---
 rtl/serial_divider.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_divider.sv
// Serial-loaded 16/8 restoring divider: three operand bytes over data_in,
// then sixteen one-bit iterations into registered quotient/remainder.
module serial_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data_in,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        done,
    output logic        busy,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_DIV,
        DIVIDE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [8:0]  rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        dbz_q, dbz_d;
    logic [9:0]  rem_wide;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_wide    = {rem_q, dvd_q[15]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = {data_in, dvd_q[7:0]};
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                dvd_d   = {dvd_q[15:8], data_in};
                state_d = LOAD_DIV;
            end
            LOAD_DIV: begin
                divisor_d = data_in;
                if (data_in == 8'h00) begin
                    quotient_d  = 16'hFFFF;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    rem_d   = '0;
                    cnt_d   = 5'd16;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // rem_q never exceeds divisor-1, so the shifted value fits in 9 bits
                if (rem_wide >= {2'b00, divisor_q}) begin
                    rem_d = rem_wide[8:0] - {1'b0, divisor_q};
                    dvd_d = {dvd_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_wide[8:0];
                    dvd_d = {dvd_q[14:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    quotient_d  = dvd_d;
                    remainder_d = rem_d[7:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    dvd_d   = {data_in, dvd_q[7:0]};
                    dbz_d   = 1'b0;
                    state_d = LOAD_LO;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOAD_LO) || (state_d == LOAD_DIV) || (state_d == DIVIDE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

endmodule
